// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave: FSM states, counter sizing
// and the mapping from CPOL/CPHA to the sclk edge that samples mosi.
package spi_pkg;

    localparam int MAX_WIDTH = 32;
    localparam int CNT_W     = $clog2(MAX_WIDTH + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

    // Mosi is sampled on rising sclk exactly when CPOL and CPHA agree.
    function automatic logic sample_on_rise(input int cpol, input int cpha);
        return (cpol == cpha);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for an asynchronous input, with single-cycle
// rise/fall strobes taken from the last two synchronised samples.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // NOTE: non-blocking assignments let every stage capture the previous
    // stage's old value, which is what makes this a real shift chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_din};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_rise = r_sync[STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_slave_mode.sv
// Oversampled SPI slave, all four CPOL/CPHA modes, full duplex, with a
// one-deep TX holding register and a one-cycle RX valid strobe.
module spi_slave_mode
    import spi_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             ss,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_wr,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             tx_underrun,
    output logic             busy
);

    localparam logic             SAMPLE_RISE = sample_on_rise(CPOL, CPHA);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(WIDTH - 1);

    spi_state_e r_state;
    spi_state_e w_state_next;

    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [WIDTH-1:0]       r_hold;
    logic                   r_hold_full;
    logic [WIDTH-1:0]       r_tx_shift;
    logic [WIDTH-1:0]       r_rx_shift;
    logic [WIDTH-1:0]       r_rx_data;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic                   r_skip;
    logic                   r_miso;
    logic                   r_rx_valid;
    logic                   r_tx_underrun;

    logic             w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall;
    logic             w_mosi, w_active, w_sample_edge, w_shift_edge;
    logic             w_frame_start, w_frame_end, w_go_idle, w_load;
    logic [WIDTH-1:0] w_load_word, w_rx_next, w_tx_adv;
    logic             w_load_first, w_cur_first, w_adv_first;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk    (clk),
        .rst    (rst),
        .i_din  (sclk),
        .o_rise (w_sclk_rise),
        .o_fall (w_sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss_sync (
        .clk    (clk),
        .rst    (rst),
        .i_din  (ss),
        .o_rise (w_ss_rise),
        .o_fall (w_ss_fall)
    );

    // Same depth as the sclk chain so w_mosi lines up with the detected edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_mosi_sync <= '0;
        else     r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
    end

    assign w_mosi        = r_mosi_sync[SYNC_STAGES-1];
    assign w_active      = (r_state == ACTIVE);
    assign w_sample_edge = w_active & (SAMPLE_RISE ? w_sclk_rise : w_sclk_fall);
    assign w_shift_edge  = w_active & (SAMPLE_RISE ? w_sclk_fall : w_sclk_rise);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_next  = r_state;
        w_frame_start = 1'b0;
        w_frame_end   = 1'b0;
        w_go_idle     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ss_fall) begin
                    w_state_next  = ACTIVE;
                    w_frame_start = 1'b1;
                end
            end
            ACTIVE: begin
                if (w_ss_rise) begin
                    w_state_next = IDLE;
                    w_go_idle    = 1'b1;
                end else if (w_sample_edge && (r_bit_cnt == CNT_LAST)) begin
                    w_frame_end = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_load       = w_frame_start | w_frame_end;
    assign w_load_word  = r_hold_full ? r_hold : '0;
    assign w_rx_next    = (MSB_FIRST != 0) ? {r_rx_shift[WIDTH-2:0], w_mosi}
                                           : {w_mosi, r_rx_shift[WIDTH-1:1]};
    assign w_tx_adv     = (MSB_FIRST != 0) ? {r_tx_shift[WIDTH-2:0], 1'b0}
                                           : {1'b0, r_tx_shift[WIDTH-1:1]};
    assign w_load_first = (MSB_FIRST != 0) ? w_load_word[WIDTH-1] : w_load_word[0];
    assign w_cur_first  = (MSB_FIRST != 0) ? r_tx_shift[WIDTH-1]  : r_tx_shift[0];
    assign w_adv_first  = (MSB_FIRST != 0) ? w_tx_adv[WIDTH-1]    : w_tx_adv[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold        <= '0;
            r_hold_full   <= 1'b0;
            r_tx_shift    <= '0;
            r_rx_shift    <= '0;
            r_rx_data     <= '0;
            r_bit_cnt     <= '0;
            r_skip        <= 1'b0;
            r_miso        <= 1'b0;
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;
        end else begin
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;

            // A write racing a frame-start load wins the holding register;
            // the load itself still takes the old contents.
            if (tx_wr) begin
                r_hold      <= tx_data;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end

            if (w_go_idle) begin
                r_miso    <= 1'b0;
                r_bit_cnt <= '0;
                r_skip    <= 1'b0;
            end else if (w_load) begin
                r_tx_shift    <= w_load_word;
                r_tx_underrun <= ~r_hold_full;
                r_rx_shift    <= '0;
                r_bit_cnt     <= '0;
                // After a reload the next shift edge only presents the first
                // bit; mode 0 also needs this for back-to-back frames.
                r_skip        <= (CPHA != 0) || w_frame_end;
                if (CPHA == 0) r_miso <= w_load_first;
                if (w_frame_end) begin
                    r_rx_data  <= w_rx_next;
                    r_rx_valid <= 1'b1;
                end
            end else begin
                if (w_sample_edge) begin
                    r_rx_shift <= w_rx_next;
                    r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
                end
                if (w_shift_edge) begin
                    if (r_skip) begin
                        r_miso <= w_cur_first;
                        r_skip <= 1'b0;
                    end else begin
                        r_tx_shift <= w_tx_adv;
                        r_miso     <= w_adv_first;
                    end
                end
            end
        end
    end

    assign miso        = r_miso;
    assign miso_oe     = w_active;
    assign busy        = w_active;
    assign tx_ready    = ~r_hold_full;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign tx_underrun = r_tx_underrun;

endmodule

// File: tb/tb_spi_slave_mode.sv
// Directed bench for spi_slave_mode: three instances (mode 0/8-bit/MSB,
// mode 3/8-bit/LSB, mode 1/16-bit/MSB) driven by one SPI master model.
module tb_spi_slave_mode;

    localparam int HALF = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk = 1'b0;
    logic mosi = 1'b0;
    logic [2:0] ss = 3'b111;
    logic [2:0] tx_wr = 3'b000;
    logic [7:0]  tx_data0 = '0;
    logic [7:0]  tx_data1 = '0;
    logic [15:0] tx_data2 = '0;

    logic [2:0]  miso, miso_oe, tx_ready, rx_valid, tx_underrun, busy;
    logic [7:0]  rx_data0, rx_data1;
    logic [15:0] rx_data2;

    bit cpol_t [3] = '{1'b0, 1'b1, 1'b0};
    bit cpha_t [3] = '{1'b0, 1'b1, 1'b1};
    bit msb_t  [3] = '{1'b1, 1'b0, 1'b1};
    int width_t[3] = '{8, 8, 16};

    int n_vec = 0;
    int n_miscmp = 0;
    int rv_cnt [3];
    int ur_cnt [3];

    always #5 clk = ~clk;

    spi_slave_mode #(.WIDTH(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2)) u_dut_m0 (
        .clk(clk), .rst(rst), .sclk(sclk), .ss(ss[0]), .mosi(mosi),
        .miso(miso[0]), .miso_oe(miso_oe[0]), .tx_data(tx_data0), .tx_wr(tx_wr[0]),
        .tx_ready(tx_ready[0]), .rx_data(rx_data0), .rx_valid(rx_valid[0]),
        .tx_underrun(tx_underrun[0]), .busy(busy[0])
    );

    spi_slave_mode #(.WIDTH(8), .CPOL(1), .CPHA(1), .MSB_FIRST(0), .SYNC_STAGES(2)) u_dut_m3 (
        .clk(clk), .rst(rst), .sclk(sclk), .ss(ss[1]), .mosi(mosi),
        .miso(miso[1]), .miso_oe(miso_oe[1]), .tx_data(tx_data1), .tx_wr(tx_wr[1]),
        .tx_ready(tx_ready[1]), .rx_data(rx_data1), .rx_valid(rx_valid[1]),
        .tx_underrun(tx_underrun[1]), .busy(busy[1])
    );

    spi_slave_mode #(.WIDTH(16), .CPOL(0), .CPHA(1), .MSB_FIRST(1), .SYNC_STAGES(3)) u_dut_w16 (
        .clk(clk), .rst(rst), .sclk(sclk), .ss(ss[2]), .mosi(mosi),
        .miso(miso[2]), .miso_oe(miso_oe[2]), .tx_data(tx_data2), .tx_wr(tx_wr[2]),
        .tx_ready(tx_ready[2]), .rx_data(rx_data2), .rx_valid(rx_valid[2]),
        .tx_underrun(tx_underrun[2]), .busy(busy[2])
    );

    // Counts high cycles of the strobes; a single-cycle pulse adds exactly one.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rx_valid[d])    rv_cnt[d]++;
            if (tx_underrun[d]) ur_cnt[d]++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] get_rx(input int d);
        case (d)
            0:       return 32'(rx_data0);
            1:       return 32'(rx_data1);
            default: return 32'(rx_data2);
        endcase
    endfunction

    // {miso, miso_oe, rx_valid, tx_ready, tx_underrun, busy}
    function automatic logic [31:0] stat(input int d);
        return 32'({miso[d], miso_oe[d], rx_valid[d], tx_ready[d], tx_underrun[d], busy[d]});
    endfunction

    task automatic write_tx(input int d, input logic [31:0] val);
        @(negedge clk);
        case (d)
            0:       tx_data0 = val[7:0];
            1:       tx_data1 = val[7:0];
            default: tx_data2 = val[15:0];
        endcase
        tx_wr[d] = 1'b1;
        @(negedge clk);
        tx_wr[d] = 1'b0;
    endtask

    task automatic ss_low(input int d);
        sclk = cpol_t[d];
        wait_clk(4);
        ss[d] = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic ss_high(input int d);
        wait_clk(HALF);
        ss[d] = 1'b1;
        wait_clk(8);
    endtask

    // Master side of nbits bit-times; sword is what the master saw on miso.
    task automatic frame(input int d, input logic [31:0] mword, input int nbits,
                         output logic [31:0] sword);
        int idx;
        sword = '0;
        for (int i = 0; i < nbits; i++) begin
            idx = msb_t[d] ? (width_t[d] - 1 - i) : i;
            if (!cpha_t[d]) begin
                mosi = mword[idx];
                wait_clk(HALF);
                sword[idx] = miso[d];
                sclk = ~cpol_t[d];
                wait_clk(HALF);
                sclk = cpol_t[d];
            end else begin
                sclk = ~cpol_t[d];
                mosi = mword[idx];
                wait_clk(HALF);
                sword[idx] = miso[d];
                sclk = cpol_t[d];
                wait_clk(HALF);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] mrx, mrx2;
        int rv0, ur0;

        wait_clk(3);
        rst = 1'b0;
        wait_clk(6);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_stat%0d", d), stat(d), 32'h04);
            check($sformatf("reset_rx%0d", d), get_rx(d), 32'h0);
        end

        // Mode 0: slave sends 0x3C, master sends 0xA5.
        write_tx(0, 32'h3C);
        check("m0_tx_ready_held", 32'(tx_ready[0]), 32'h0);
        rv0 = rv_cnt[0];
        ss_low(0);
        check("m0_tx_ready_loaded", 32'(tx_ready[0]), 32'h1);
        check("m0_busy_oe", 32'({busy[0], miso_oe[0]}), 32'h3);
        frame(0, 32'hA5, 8, mrx);
        ss_high(0);
        check("m0_miso_word", mrx, 32'h3C);
        check("m0_rx_data", get_rx(0), 32'hA5);
        check("m0_rx_valid_cycles", 32'(rv_cnt[0] - rv0), 32'h1);
        check("m0_idle_stat", 32'({miso[0], miso_oe[0], busy[0]}), 32'h0);

        // Mode 3, LSB first: slave sends 0x5A, master sends 0x81.
        rv0 = rv_cnt[1];
        write_tx(1, 32'h5A);
        ss_low(1);
        frame(1, 32'h81, 8, mrx);
        ss_high(1);
        check("m3_miso_word", mrx, 32'h5A);
        check("m3_rx_data", get_rx(1), 32'h81);
        check("m3_rx_valid_cycles", 32'(rv_cnt[1] - rv0), 32'h1);

        // Back-to-back frames on mode 0 with ss held low.
        rv0 = rv_cnt[0];
        ur0 = ur_cnt[0];
        write_tx(0, 32'h11);
        ss_low(0);
        write_tx(0, 32'h22);
        frame(0, 32'hC3, 8, mrx);
        check("b2b_rx_first", get_rx(0), 32'hC3);
        write_tx(0, 32'h33);
        frame(0, 32'h96, 8, mrx2);
        ss_high(0);
        check("b2b_miso_first", mrx, 32'h11);
        check("b2b_miso_second", mrx2, 32'h22);
        check("b2b_rx_second", get_rx(0), 32'h96);
        check("b2b_rx_valid_cycles", 32'(rv_cnt[0] - rv0), 32'h2);
        check("b2b_underruns", 32'(ur_cnt[0] - ur0), 32'h0);

        // Partial frame (5 of 8) is dropped; the next full frame is intact.
        rv0 = rv_cnt[0];
        write_tx(0, 32'h55);
        ss_low(0);
        frame(0, 32'hFF, 5, mrx);
        ss_high(0);
        check("partial_no_valid", 32'(rv_cnt[0] - rv0), 32'h0);
        check("partial_rx_kept", get_rx(0), 32'h96);
        write_tx(0, 32'h0F);
        ss_low(0);
        frame(0, 32'h3A, 8, mrx);
        ss_high(0);
        check("after_partial_rx", get_rx(0), 32'h3A);
        check("after_partial_miso", mrx, 32'h0F);

        // 16-bit mode 1 with an empty holding register at frame start.
        ur0 = ur_cnt[2];
        rv0 = rv_cnt[2];
        ss_low(2);
        check("w16_underrun_start", 32'(ur_cnt[2] - ur0), 32'h1);
        write_tx(2, 32'h1234);
        frame(2, 32'hBEEF, 16, mrx);
        ss_high(2);
        check("w16_miso_zeros", mrx, 32'h0);
        check("w16_rx_data", get_rx(2), 32'hBEEF);
        check("w16_rx_valid_cycles", 32'(rv_cnt[2] - rv0), 32'h1);
        check("w16_underrun_total", 32'(ur_cnt[2] - ur0), 32'h1);

        // Reset in the middle of a frame, then a clean transfer of 0x42.
        write_tx(0, 32'h99);
        ss_low(0);
        frame(0, 32'hFF, 3, mrx);
        rst = 1'b1;
        wait_clk(2);
        check("midrst_stat", stat(0), 32'h04);
        check("midrst_rx", get_rx(0), 32'h0);
        rst = 1'b0;
        wait_clk(10);
        check("midrst_no_restart", 32'(busy[0]), 32'h0);
        ss_high(0);
        rv0 = rv_cnt[0];
        write_tx(0, 32'h24);
        ss_low(0);
        frame(0, 32'h42, 8, mrx);
        ss_high(0);
        check("postrst_rx", get_rx(0), 32'h42);
        check("postrst_miso", mrx, 32'h24);
        check("postrst_rx_valid_cycles", 32'(rv_cnt[0] - rv0), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
